// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op and state encodings plus timing constants shared
// by the iterative multiply/divide unit (no ports).
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  localparam int MULDIV_ITER = 32;
  localparam int MULDIV_LAT  = 34;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 shift-add multiply or restoring divide step
// per en; load seeds hi=0, lo=a, divisor/multiplicand=b. MULDIV_DIV_EN
// adds the div select input and the restoring-divide datapath.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load,
  input  logic        en,
`ifdef MULDIV_DIV_EN
  input  logic        div,
`endif
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] b_q;
  logic [31:0] hi_nx;
  logic [31:0] lo_nx;
  logic [32:0] sum;
`ifdef MULDIV_DIV_EN
  logic [32:0] rsh;
  logic [31:0] dif;
`endif

  assign sum = {1'b0, hi} + {1'b0, b_q};

  always_comb begin
    // multiply: add on lsb of multiplier, then shift {hi,lo} right
    if (lo[0]) begin
      hi_nx = sum[32:1];
      lo_nx = {sum[0], lo[31:1]};
    end else begin
      hi_nx = {1'b0, hi[31:1]};
      lo_nx = {hi[0], lo[31:1]};
    end
`ifdef MULDIV_DIV_EN
    // divide: partial remainder < divisor, so the difference fits 32b
    rsh = {hi, lo[31]};
    dif = rsh[31:0] - b_q;
    if (div) begin
      if (rsh >= {1'b0, b_q}) begin
        hi_nx = dif;
        lo_nx = {lo[30:0], 1'b1};
      end else begin
        hi_nx = rsh[31:0];
        lo_nx = {lo[30:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hi  <= '0;
      lo  <= '0;
      b_q <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= a;
      b_q <= b;
    end else if (en) begin
      hi  <= hi_nx;
      lo  <= lo_nx;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner, FSM, counter and sign fixup for MULT/DIV.
// Ports: CLK, RESET, start, op, opA, opB, mf_req -> HI, LO, busy, done,
// FREEZE. Macro MULDIV_DIV_EN enables DIV/DIVU (else they are no-ops).
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        mf_req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        FREEZE
);

  state_e      state;
  op_e         opc;
  logic [4:0]  cnt;
  logic        go;
  logic        sgn_op;
  logic        neg_x;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] hi_raw;
  logic [31:0] lo_raw;
  logic [63:0] prod;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;
`ifdef MULDIV_DIV_EN
  logic        div_go;
  logic        is_div;
  logic        neg_r;
`endif

  assign opc = op_e'(op);

  always_comb begin
    go     = 1'b0;
    sgn_op = 1'b0;
`ifdef MULDIV_DIV_EN
    div_go = 1'b0;
`endif
    case (opc)
      OP_MULT:  begin go = 1'b1; sgn_op = 1'b1; end
      OP_MULTU: go = 1'b1;
`ifdef MULDIV_DIV_EN
      OP_DIV:   begin go = 1'b1; sgn_op = 1'b1; div_go = 1'b1; end
      OP_DIVU:  begin go = 1'b1; div_go = 1'b1; end
`endif
      default:  ;
    endcase
  end

  assign a_mag = (sgn_op & opA[31]) ? -opA : opA;
  assign b_mag = (sgn_op & opB[31]) ? -opB : opB;

  muldiv_step u_step (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (state == S_IDLE && start && go),
    .en    (state == S_CALC),
`ifdef MULDIV_DIV_EN
    .div   (is_div),
`endif
    .a     (a_mag),
    .b     (b_mag),
    .hi    (hi_raw),
    .lo    (lo_raw)
  );

  always_comb begin
    prod   = neg_x ? -{hi_raw, lo_raw} : {hi_raw, lo_raw};
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      fix_lo = neg_x ? -lo_raw : lo_raw;
      fix_hi = neg_r ? -hi_raw : hi_raw;
    end
`endif
  end

  assign FREEZE = busy & (start | mf_req);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      HI     <= '0;
      LO     <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      neg_x  <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && go) begin
            state <= S_CALC;
            cnt   <= 5'(MULDIV_ITER - 1);
            busy  <= 1'b1;
`ifdef MULDIV_DIV_EN
            // x/0 keeps the all-ones quotient unsigned
            neg_x  <= sgn_op & (opA[31] ^ opB[31])
                      & ~(div_go & (opB == '0));
            is_div <= div_go;
            neg_r  <= sgn_op & opA[31];
`else
            neg_x  <= sgn_op & (opA[31] ^ opB[31]);
`endif
          end else if (start && opc == OP_MTHI) begin
            HI <= opA;
          end else if (start && opc == OP_MTLO) begin
            LO <= opA;
          end
        end
        S_CALC: begin
          if (cnt == '0) begin
            state <= S_FIX;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_FIX: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port start  input  1  request from EXE to begin the operation on op.
REQ-004 SHALL have port op  input  3  operation code, encoded per package enum: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-005 SHALL have port opA  input  32  operand A; dividend for divides; source value for MTHI/MTLO.
REQ-006 SHALL have port opB  input  32  operand B; divisor for divides.
REQ-007 SHALL have port mf_req  input  1  EXE holds an MFHI/MFLO needing HI/LO.
REQ-008 SHALL have port HI  output  32  architectural HI register.
REQ-009 SHALL have port LO  output  32  architectural LO register.
REQ-010 SHALL have port busy  output  1  operation in progress; high in CALC and FIX states.
REQ-011 SHALL have port done  output  1  one-cycle pulse in the cycle HI/LO are written by MULT/DIV.
REQ-012 SHALL have port FREEZE  output  1  pipeline stall request, combinational: busy & (start | mf_req).

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX.
REQ-014 IDLE with start and op MULT/MULTU/DIV/DIVU: SHALL latch magnitudes and sign flags, load counter to 31, and go to CALC.
REQ-015 IDLE with start and MTHI/MTLO: SHALL write opA to HI/LO at that edge, stay IDLE, leave busy low and not pulse done.
REQ-016 CALC: SHALL perform one radix-2 step per cycle (multiply shift-add; divide restoring) and decrement the counter; at counter 0 go to FIX.
REQ-017 FIX: SHALL negate results for signed ops (product if signs differ; quotient if signs differ; remainder takes dividend sign), write HI/LO, pulse done, and return to IDLE.
REQ-018 Latency SHALL be 34 cycles from accept edge to the HI/LO write edge: 1 load + 32 CALC + 1 FIX.
REQ-019 Multiply SHALL write HI = product[63:32] and LO = product[31:0]; divide SHALL write LO = quotient and HI = remainder.
REQ-020 start while busy (including the FIX cycle) SHALL NOT be accepted; the requester holds start under FREEZE and it is accepted in the following IDLE cycle.
REQ-021 Divide by zero SHALL take full latency and write LO = 32'hFFFFFFFF and HI = dividend, with no sign fixup.
REQ-022 Signed DIV of 32'h80000000 by 32'hFFFFFFFF SHALL write LO = 32'h80000000 and HI = 0.
REQ-023 mf_req in IDLE SHALL NOT freeze; HI/LO outputs SHALL always reflect the registered values.

Reset
REQ-024 RESET high SHALL asynchronously force IDLE, HI = LO = 0, counter = 0, busy = 0, done = 0, and clear internal accumulators.
REQ-025 Reset asserted mid-operation SHALL abort it with no HI/LO write; the first accept after deassertion SHALL behave as from power-up.

Configuration
REQ-026 Macro MULDIV_DIV_EN defined: DIV/DIVU SHALL be supported as above.
REQ-027 Macro MULDIV_DIV_EN undefined: DIV/DIVU SHALL be accepted as no-ops (HI/LO unchanged, busy and done stay low, no freeze), and the divider datapath SHALL be absent.

Structure
REQ-028 Shared package muldiv_pkg SHALL hold the op enum (3 bits), the state enum, and the constants MULDIV_ITER = 32 and MULDIV_LAT = 34.
REQ-029 The iterative datapath SHALL be one sub-module muldiv_step (one shift-add or restore step per enable; combinational plus accumulator registers); the FSM, counter and sign fixup SHALL remain in muldiv_ctrl.

Verification
REQ-030 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> done 34 cycles after accept; HI = 32'hFFFFFFFE, LO = 32'h00000001.
REQ-031 MULT -7 x 3 -> HI = 32'hFFFFFFFF, LO = 32'hFFFFFFEB.
REQ-032 DIV -7 / 2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF; DIVU 100 / 0 -> LO = 32'hFFFFFFFF, HI = 100.
REQ-033 mf_req raised 5 cycles after accepting a MULT -> FREEZE high until the done cycle inclusive, low the cycle after.
REQ-034 Back-to-back start held through FIX -> second op accepted exactly one cycle after done; MTLO 32'h1234 in IDLE -> LO = 32'h1234 next edge, busy stays 0.
REQ-035 RESET pulsed during CALC of MULTU 5 x 5 -> HI = LO = 0, state IDLE, no done pulse; a fresh MULTU 5 x 5 -> LO = 25.
